// File: rtl/cache_responder_if.sv
// Cache interface opcodes and the request/valid handshake bundle.
// The bidirectional data bus stays a separate port on the endpoint.
package cachepkg;
  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } inst_t;
endpackage

interface cache_responder_if #(
  parameter type ADDRSPACE = logic [31:0]
);
  cachepkg::inst_t operation;
  ADDRSPACE        addr;
  logic            request;
  logic            valid;

  modport master (output operation, output addr, output request, input valid);
  modport slave  (input operation, input addr, input request, output valid);
endinterface

// File: rtl/cache_responder.sv
// Slave endpoint of the cache interface: a word-addressed backing store that
// answers READ/WRITE transactions LATENCY cycles after the request is sampled.
module cache_responder #(
  parameter type WORD      = logic [7:0],
  parameter type ADDRSPACE = logic [31:0],
  parameter int  DEPTH     = 256,
  parameter int  LATENCY   = 2
) (
  input  logic             clock,
  input  logic             reset,
  cache_responder_if.slave bus,
  inout  wire WORD         data
);
  import cachepkg::*;

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_fire;
  logic [7:0]    r_cnt;
  inst_t         r_op;
  logic [AW-1:0] r_addr;
  WORD           r_wdata;
  WORD           r_rdata;
  logic          r_valid;
  logic          r_drive_en;
  WORD           r_mem [DEPTH];
  ADDRSPACE      w_addr;
  logic          w_addr_unused;

  // Only the low AW address bits select a word; the rest wrap silently.
  assign w_addr        = bus.addr;
  assign w_addr_unused = ^w_addr;

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      IDLE:    if (bus.request) w_state_nxt = BUSY;
      BUSY:    if (r_cnt == 8'd0) begin
                 w_fire      = 1'b1;
                 w_state_nxt = ACK;
               end
      ACK:     if (!bus.request) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= 8'd0;
      r_valid    <= 1'b0;
      r_drive_en <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (bus.request) r_cnt <= 8'(LATENCY - 1);
        BUSY:    if (w_fire) begin
                   r_valid    <= 1'b1;
                   r_drive_en <= (r_op == READ);
                 end else begin
                   r_cnt <= r_cnt - 8'd1;
                 end
        ACK:     if (!bus.request) begin
                   r_valid    <= 1'b0;
                   r_drive_en <= 1'b0;
                 end
        default: ;
      endcase
    end
  end

  // NOTE: the store and the capture registers are deliberately not reset; memory survives reset.
  always_ff @(posedge clock) begin
    if (r_state == IDLE && bus.request) begin
      r_op    <= bus.operation;
      r_addr  <= w_addr[AW-1:0];
      r_wdata <= data;
    end
    // Reset on the commit edge abandons the transaction, write included.
    if (w_fire && !reset) begin
      if (r_op == WRITE) r_mem[r_addr] <= r_wdata;
      if (r_op == READ)  r_rdata       <= r_mem[r_addr];
    end
  end

  assign bus.valid = r_valid;
  assign data      = r_drive_en ? r_rdata : 'z;

endmodule

// File: tb/tb_cache_responder.sv
// Directed bench for cache_responder: one instance at DEPTH=16/LATENCY=3 and
// one at LATENCY=1; data buses are pulled high so a released bus reads 0xFF.
module tb_cache_responder;
  import cachepkg::*;

  logic        clk;
  logic        rst;
  logic        req_a, req_b;
  logic        drv_a, drv_b;
  inst_t       tb_op;
  logic [31:0] tb_addr;
  logic [7:0]  tb_wdat;
  int          n_cmp;
  int          n_err;

  tri1 [7:0] data_a;
  tri1 [7:0] data_b;

  cache_responder_if #(.ADDRSPACE(logic [31:0])) bus_a ();
  cache_responder_if #(.ADDRSPACE(logic [31:0])) bus_b ();

  assign bus_a.operation = tb_op;
  assign bus_a.addr      = tb_addr;
  assign bus_a.request   = req_a;
  assign bus_b.operation = tb_op;
  assign bus_b.addr      = tb_addr;
  assign bus_b.request   = req_b;
  assign data_a = drv_a ? tb_wdat : 8'bz;
  assign data_b = drv_b ? tb_wdat : 8'bz;

  cache_responder #(
    .WORD(logic [7:0]), .ADDRSPACE(logic [31:0]), .DEPTH(16), .LATENCY(3)
  ) u_dut_a (
    .clock(clk), .reset(rst), .bus(bus_a.slave), .data(data_a)
  );

  cache_responder #(
    .WORD(logic [7:0]), .ADDRSPACE(logic [31:0]), .DEPTH(256), .LATENCY(1)
  ) u_dut_b (
    .clock(clk), .reset(rst), .bus(bus_b.slave), .data(data_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_valid(input bit sel);
    return sel ? bus_b.valid : bus_a.valid;
  endfunction

  function automatic logic [7:0] get_data(input bit sel);
    return sel ? data_b : data_a;
  endfunction

  task automatic set_req(input bit sel, input logic v);
    if (sel) req_b = v;
    else     req_a = v;
  endtask

  task automatic set_drv(input bit sel, input logic v);
    if (sel) drv_b = v;
    else     drv_a = v;
  endtask

  // Full handshake starting at a negedge; returns at the negedge where valid
  // has been seen low again, so a following call starts back-to-back.
  task automatic txn(input bit sel, input inst_t op, input logic [31:0] a,
                     input logic [7:0] wd, input logic [7:0] exp_rd,
                     input int lat, input bit scramble, input string tag);
    int         k;
    bit         got;
    logic [7:0] exp_bus;
    exp_bus = (op == READ) ? exp_rd : 8'hFF;
    tb_op   = op;
    tb_addr = a;
    tb_wdat = wd;
    set_drv(sel, op != READ);
    set_req(sel, 1'b1);
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (scramble) begin
          tb_addr = ~a;
          tb_op   = READ;
          tb_wdat = ~wd;
        end else begin
          set_drv(sel, 1'b0);
        end
      end
      got = get_valid(sel);
    end
    set_drv(sel, 1'b0);
    #1;
    check({tag, "_lat"}, 32'(k - 1), 32'(lat));
    check({tag, "_data"}, {24'd0, get_data(sel)}, {24'd0, exp_bus});
    @(negedge clk);
    check({tag, "_hold"}, {23'd0, get_valid(sel), get_data(sel)}, {23'd0, 1'b1, exp_bus});
    set_req(sel, 1'b0);
    @(negedge clk);
    check({tag, "_rel"}, {23'd0, get_valid(sel), get_data(sel)}, {23'd0, 1'b0, 8'hFF});
  endtask

  initial begin
    int  n_hi;
    int  k;
    bit  got;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    req_a   = 1'b0;
    req_b   = 1'b0;
    drv_a   = 1'b0;
    drv_b   = 1'b0;
    tb_op   = NOP;
    tb_addr = 32'd0;
    tb_wdat = 8'd0;

    // Reset, then an idle stretch with request low.
    repeat (2) @(negedge clk);
    check("rst_valid_a", {31'd0, bus_a.valid}, 32'd0);
    check("rst_valid_b", {31'd0, bus_b.valid}, 32'd0);
    check("rst_data_a", {24'd0, data_a}, 32'h0000_00FF);
    check("rst_data_b", {24'd0, data_b}, 32'h0000_00FF);
    rst  = 1'b0;
    n_hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_a.valid || bus_b.valid) n_hi++;
    end
    check("idle_quiet", 32'(n_hi), 32'd0);

    // Write then read back, LATENCY=3.
    txn(1'b0, WRITE, 32'h05, 8'hA5, 8'h00, 3, 1'b0, "wr05");
    @(negedge clk);
    txn(1'b0, READ, 32'h05, 8'h00, 8'hA5, 3, 1'b0, "rd05");
    @(negedge clk);

    // Address wrap on a 16-word store.
    txn(1'b0, WRITE, 32'h13, 8'h3C, 8'h00, 3, 1'b0, "wr13");
    @(negedge clk);
    txn(1'b0, READ, 32'h03, 8'h00, 8'h3C, 3, 1'b0, "rd03");
    @(negedge clk);
    txn(1'b0, READ, 32'hFFFF_FFF3, 8'h00, 8'h3C, 3, 1'b0, "rdhi3");
    @(negedge clk);

    // NOP-class operations complete the handshake but leave the store alone.
    txn(1'b0, NOP, 32'h05, 8'h11, 8'h00, 3, 1'b0, "nop05");
    @(negedge clk);
    txn(1'b0, FLUSH, 32'h05, 8'h22, 8'h00, 3, 1'b0, "flush05");
    @(negedge clk);
    txn(1'b0, READ, 32'h05, 8'h00, 8'hA5, 3, 1'b0, "rd05b");
    @(negedge clk);

    // Inputs changed during BUSY must not affect the latched transaction.
    txn(1'b0, WRITE, 32'h08, 8'h88, 8'h00, 3, 1'b0, "wr08");
    @(negedge clk);
    txn(1'b0, WRITE, 32'h07, 8'h6E, 8'h00, 3, 1'b1, "wr07s");
    @(negedge clk);
    txn(1'b0, READ, 32'h07, 8'h00, 8'h6E, 3, 1'b0, "rd07");
    @(negedge clk);
    txn(1'b0, READ, 32'h08, 8'h00, 8'h88, 3, 1'b0, "rd08");
    @(negedge clk);

    // Request dropped during BUSY: one-cycle valid pulse, write still lands.
    tb_op = WRITE; tb_addr = 32'h0A; tb_wdat = 8'h42; drv_a = 1'b1; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0; drv_a = 1'b0;
    repeat (2) @(negedge clk);
    check("pv_pre", {31'd0, bus_a.valid}, 32'd0);
    @(negedge clk);
    check("pv_rise", {31'd0, bus_a.valid}, 32'd1);
    @(negedge clk);
    check("pv_fall", {31'd0, bus_a.valid}, 32'd0);
    @(negedge clk);
    txn(1'b0, READ, 32'h0A, 8'h00, 8'h42, 3, 1'b0, "rd0a");
    @(negedge clk);

    // LATENCY=1 instance: preload, then two reads back-to-back.
    txn(1'b1, WRITE, 32'h00, 8'h10, 8'h00, 1, 1'b0, "b_wr0");
    @(negedge clk);
    txn(1'b1, WRITE, 32'h01, 8'h21, 8'h00, 1, 1'b0, "b_wr1");
    @(negedge clk);
    txn(1'b1, READ, 32'h00, 8'h00, 8'h10, 1, 1'b0, "b_rd0");
    txn(1'b1, READ, 32'h01, 8'h00, 8'h21, 1, 1'b0, "b_rd1");
    @(negedge clk);

    // Reset landing on the commit edge of a WRITE: nothing commits, no valid.
    txn(1'b0, WRITE, 32'h09, 8'hA5, 8'h00, 3, 1'b0, "wr09");
    @(negedge clk);
    tb_op = WRITE; tb_addr = 32'h09; tb_wdat = 8'h77; drv_a = 1'b1; req_a = 1'b1;
    @(negedge clk);
    drv_a = 1'b0; req_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rbusy_valid", {31'd0, bus_a.valid}, 32'd0);
    n_hi = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_a.valid) n_hi++;
    end
    check("rbusy_quiet", 32'(n_hi), 32'd0);
    txn(1'b0, READ, 32'h09, 8'h00, 8'hA5, 3, 1'b0, "rd09");
    @(negedge clk);

    // Reset during ACK of a read drops valid and releases the bus on that edge.
    tb_op = READ; tb_addr = 32'h05; req_a = 1'b1;
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      got = bus_a.valid;
    end
    check("rack_lat", 32'(k - 1), 32'd3);
    check("rack_data", {24'd0, data_a}, 32'h0000_00A5);
    rst = 1'b1;
    @(negedge clk);
    check("rack_valid", {31'd0, bus_a.valid}, 32'd0);
    check("rack_z", {24'd0, data_a}, 32'h0000_00FF);
    rst   = 1'b0;
    req_a = 1'b0;
    @(negedge clk);
    check("rack_after", {31'd0, bus_a.valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
